// File: rtl/mux3_arb_pkg.sv
// mux3_arbiter shared types and helpers.
// Grant encodings and round-robin selection.
package mux3_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [1:0] SEL_D0 = 2'b00;
  localparam logic [1:0] SEL_D1 = 2'b01;
  localparam logic [1:0] SEL_D2 = 2'b10;

  // Successor of a grant, modulo three requesters.
  function automatic logic [1:0] sel_next(
    input logic [1:0] s
  );
    case (s)
      SEL_D0:  return SEL_D1;
      SEL_D1:  return SEL_D2;
      default: return SEL_D0;
    endcase
  endfunction

  // Request bit of one requester.
  function automatic logic req_of(
    input logic [2:0] v,
    input logic [1:0] s
  );
    case (s)
      SEL_D0:  return v[0];
      SEL_D1:  return v[1];
      SEL_D2:  return v[2];
      default: return 1'b0;
    endcase
  endfunction

  // First requesting index at ptr, ptr+1, ptr+2.
  function automatic logic [1:0] rr_pick(
    input logic [1:0] ptr,
    input logic [2:0] v
  );
    logic [1:0] c1;
    logic [1:0] c2;
    c1 = sel_next(ptr);
    c2 = sel_next(c1);
    if (req_of(v, ptr)) return ptr;
    if (req_of(v, c1))  return c1;
    return c2;
  endfunction

endpackage

// File: rtl/mux3_arbiter_mux3.sv
// Three-way data selector.
// s = 00/01/10 picks a/b/c.
module mux3
  import mux3_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [1:0]       s,
  output logic [WIDTH-1:0] y
);

  // Select one input by grant encoding.
  always_comb begin
    y = a;
    case (s)
      SEL_D1:  y = b;
      SEL_D2:  y = c;
      default: y = a;
    endcase
  end

endmodule

// File: rtl/mux3_arbiter.sv
// Packet-level round-robin arbiter over
// three valid/ready requesters.
module mux3_arbiter
  import mux3_arb_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       in_valid,
  input  logic [2:0]       in_last,
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic [WIDTH-1:0] d2,
  output logic [2:0]       in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [1:0]       sel
);

  localparam logic [7:0] MAXB = 8'(MAX_BEATS);

  state_t     state;
  state_t     state_nx;
  logic [1:0] ptr;
  logic [7:0] beats;
  logic       xfer;
  logic       done;

  mux3 #(
    .WIDTH(WIDTH)
  ) u_mux (
    .a(d0),
    .b(d1),
    .c(d2),
    .s(sel),
    .y(out_data)
  );

  // Last flag follows the same grant encoding.
  always_comb begin
    out_last = in_last[0];
    case (sel)
      SEL_D1:  out_last = in_last[1];
      SEL_D2:  out_last = in_last[2];
      default: out_last = in_last[0];
    endcase
  end

  // Transfer and packet-release conditions.
  always_comb begin
    xfer = out_valid && out_ready;
    done = xfer &&
           (out_last || (beats + 8'd1 == MAXB));
  end

  // State, grant, pointer and beat counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= SEL_D0;
      sel   <= SEL_D0;
      beats <= 8'd0;
    end else begin
      state <= state_nx;
      if (state == IDLE && |in_valid) begin
        sel   <= rr_pick(ptr, in_valid);
        beats <= 8'd0;
      end
      if (xfer) beats <= beats + 8'd1;
      if (done) ptr <= sel_next(sel);
    end
  end

  // Next state: grant on any request,
  // release on last or beat limit.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|in_valid) state_nx = BUSY;
      BUSY:    if (done) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs; reset blocks any
  // transfer in the cycle it is sampled.
  always_comb begin
    out_valid = 1'b0;
    in_ready  = 3'b000;
    if (state == BUSY && !reset) begin
      case (sel)
        SEL_D0: begin
          out_valid   = in_valid[0];
          in_ready[0] = out_ready;
        end
        SEL_D1: begin
          out_valid   = in_valid[1];
          in_ready[1] = out_ready;
        end
        SEL_D2: begin
          out_valid   = in_valid[2];
          in_ready[2] = out_ready;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mux3_arbiter.sv
// Bench for mux3_arbiter: packet-level model,
// directed scenarios and random traffic.
module tb_mux3_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [2:0]   in_valid = 3'b000;
  logic [2:0]   in_last = 3'b000;
  logic [W-1:0] d0 = '0;
  logic [W-1:0] d1 = '0;
  logic [W-1:0] d2 = '0;
  logic         out_ready = 1'b0;

  logic [2:0]   ir_a, ir_b;
  logic         ov_a, ov_b;
  logic         ol_a, ol_b;
  logic [W-1:0] od_a, od_b;
  logic [1:0]   sel_a, sel_b;

  always #5 clk = ~clk;

  mux3_arbiter #(
    .WIDTH(W),
    .MAX_BEATS(16)
  ) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_last(in_last),
    .d0(d0), .d1(d1), .d2(d2),
    .in_ready(ir_a), .out_valid(ov_a),
    .out_ready(out_ready), .out_data(od_a),
    .out_last(ol_a), .sel(sel_a)
  );

  mux3_arbiter #(
    .WIDTH(W),
    .MAX_BEATS(3)
  ) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_last(in_last),
    .d0(d0), .d1(d1), .d2(d2),
    .in_ready(ir_b), .out_valid(ov_b),
    .out_ready(out_ready), .out_data(od_b),
    .out_last(ol_b), .sel(sel_b)
  );

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  // Packet-level model, one per instance.
  bit m_busy[2] = '{0, 0};
  int m_g[2]    = '{0, 0};
  int m_ptr[2]  = '{0, 0};
  int m_cnt[2]  = '{0, 0};
  int m_max[2]  = '{16, 3};

  bit          rec = 0;
  logic [1:0]  qa[$];
  logic [1:0]  qb[$];
  int          ta[$];
  int          tb[$];

  function automatic void chk(
    input string       nm,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endfunction

  function automatic logic [W-1:0] dsel(
    input int g
  );
    if (g == 0) return d0;
    if (g == 1) return d1;
    return d2;
  endfunction

  always @(posedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (reset) begin
        m_busy[i] = 0;
        m_g[i]    = 0;
        m_ptr[i]  = 0;
        m_cnt[i]  = 0;
      end else if (!m_busy[i]) begin
        for (int k = 2; k >= 0; k--) begin
          if (in_valid[(m_ptr[i] + k) % 3]) begin
            m_g[i]    = (m_ptr[i] + k) % 3;
            m_busy[i] = 1;
            m_cnt[i]  = 0;
          end
        end
      end else if (in_valid[m_g[i]] &&
                   out_ready) begin
        m_cnt[i]++;
        if (in_last[m_g[i]] ||
            m_cnt[i] == m_max[i]) begin
          m_busy[i] = 0;
          m_ptr[i]  = (m_g[i] + 1) % 3;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic       e_ov;
      logic [2:0] e_ir;
      logic       ov;
      logic       ol;
      logic [2:0] ir;
      logic [1:0] sl;
      logic [W-1:0] od;
      ov = (i == 0) ? ov_a : ov_b;
      ol = (i == 0) ? ol_a : ol_b;
      ir = (i == 0) ? ir_a : ir_b;
      sl = (i == 0) ? sel_a : sel_b;
      od = (i == 0) ? od_a : od_b;
      e_ov = !reset && m_busy[i] &&
             in_valid[m_g[i]];
      e_ir = (!reset && m_busy[i] && out_ready)
             ? 3'(1 << m_g[i]) : 3'b000;
      chk($sformatf("out_valid%0d", i),
          32'(ov), 32'(e_ov));
      chk($sformatf("in_ready%0d", i),
          32'(ir), 32'(e_ir));
      chk($sformatf("sel%0d", i),
          32'(sl), m_g[i]);
      if (e_ov) begin
        chk($sformatf("out_data%0d", i),
            32'(od), 32'(dsel(m_g[i])));
        chk($sformatf("out_last%0d", i),
            32'(ol), 32'(in_last[m_g[i]]));
      end
    end
  end

  always @(negedge clk) begin
    if (rec) begin
      if (ov_a && out_ready) begin
        qa.push_back(sel_a);
        ta.push_back(cyc);
      end
      if (ov_b && out_ready) begin
        qb.push_back(sel_b);
        tb.push_back(cyc);
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [2:0] v,
    input logic [2:0] l,
    input logic       r
  );
    in_valid  = v;
    in_last   = l;
    out_ready = r;
    d0 = W'($urandom);
    d1 = W'($urandom);
    d2 = W'($urandom);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(3'b000, 3'b000, 1'b0);
    next_cycle();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic clear_rec();
    qa.delete();
    qb.delete();
    ta.delete();
    tb.delete();
    rec = 1;
  endtask

  int exp_rr[4] = '{0, 1, 2, 0};

  initial begin
    // Reset state.
    @(negedge clk);
    chk("rst_out_valid", 32'(ov_a), 0);
    chk("rst_in_ready", 32'(ir_a), 0);
    chk("rst_sel", 32'(sel_a), 0);

    // Round robin 0,1,2,0 with idle gaps.
    do_reset();
    clear_rec();
    for (int k = 0; k < 8; k++) begin
      drive(3'b111, 3'b111, 1'b1);
      next_cycle();
    end
    rec = 0;
    chk("rr_count", qa.size(), 4);
    if (qa.size() >= 4) begin
      for (int j = 0; j < 4; j++)
        chk($sformatf("rr_order%0d", j),
            32'(qa[j]), exp_rr[j]);
      for (int j = 1; j < 4; j++)
        chk($sformatf("rr_gap%0d", j),
            ta[j] - ta[j-1], 2);
    end

    // Four-beat packet holds grant.
    do_reset();
    clear_rec();
    for (int k = 0; k < 8; k++) begin
      if (k == 0)
        drive(3'b010, 3'b000, 1'b1);
      else if (k <= 4)
        drive(3'b011,
              (k == 4) ? 3'b010 : 3'b000, 1'b1);
      else if (k <= 6)
        drive(3'b001, 3'b001, 1'b1);
      else
        drive(3'b000, 3'b000, 1'b1);
      next_cycle();
    end
    rec = 0;
    chk("pkt_count", qa.size(), 5);
    if (qa.size() == 5) begin
      for (int j = 0; j < 4; j++)
        chk($sformatf("pkt_sel%0d", j),
            32'(qa[j]), 1);
      chk("pkt_next", 32'(qa[4]), 0);
      chk("pkt_gap", ta[4] - ta[3], 2);
    end

    // Beat limit of 3 forces release.
    do_reset();
    clear_rec();
    for (int k = 0; k < 6; k++) begin
      drive((k == 0) ? 3'b100 : 3'b110,
            3'b000, 1'b1);
      next_cycle();
    end
    rec = 0;
    chk("max_count", qb.size(), 4);
    if (qb.size() == 4) begin
      for (int j = 0; j < 3; j++)
        chk($sformatf("max_sel%0d", j),
            32'(qb[j]), 2);
      chk("max_regrant", 32'(qb[3]), 1);
      chk("max_gap", tb[3] - tb[2], 2);
    end
    chk("nomax_count", qa.size(), 5);

    // Back-pressure stall.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      drive(3'b001, 3'b000,
            (k >= 3 && k <= 7) ? 1'b0 : 1'b1);
      @(negedge clk);
      if (k >= 3 && k <= 7) begin
        chk("stall_ir", 32'(ir_b), 0);
        chk("stall_sel", 32'(sel_b), 0);
      end
      if (k == 8)
        chk("stall_xfer3", 32'(ov_b), 1);
      if (k == 9) begin
        chk("stall_rel", 32'(ov_b), 0);
        chk("stall_hold", 32'(ov_a), 1);
      end
      next_cycle();
    end

    // Reset mid-packet.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k <= 1)
        drive(3'b001, 3'b001, 1'b1);
      else
        drive(3'b011, 3'b000, 1'b1);
      reset = (k == 5);
      @(negedge clk);
      if (k == 3)
        chk("mid_sel", 32'(sel_a), 1);
      if (k == 5) begin
        chk("mid_rst_ov", 32'(ov_a), 0);
        chk("mid_rst_ir", 32'(ir_a), 0);
      end
      if (k == 6) begin
        chk("post_rst_ov", 32'(ov_a), 0);
        chk("post_rst_sel", 32'(sel_a), 0);
        chk("post_rst_ir", 32'(ir_a), 0);
      end
      if (k == 7) begin
        chk("post_rst_grant", 32'(sel_a), 0);
        chk("post_rst_valid", 32'(ov_a), 1);
      end
      next_cycle();
    end
    reset = 1'b0;

    // Granted valid drops, grant held.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k <= 1)
        drive(3'b001, 3'b000, 1'b1);
      else if (k <= 3)
        drive(3'b110, 3'b000, 1'b1);
      else
        drive(3'b111, 3'b001, 1'b1);
      @(negedge clk);
      if (k == 2 || k == 3) begin
        chk("gap_ov", 32'(ov_a), 0);
        chk("gap_sel", 32'(sel_a), 0);
        chk("gap_ir", 32'(ir_a), 1);
      end
      if (k == 4) begin
        chk("resume_ov", 32'(ov_a), 1);
        chk("resume_sel", 32'(sel_a), 0);
      end
      next_cycle();
    end

    // Random traffic against the model.
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 199) == 0);
      drive(3'($urandom),
            {($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 3) == 0)},
            ($urandom_range(0, 3) != 0));
      next_cycle();
    end
    reset = 1'b0;
    next_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
